weight_read_sequencer: RTL and testbench
========================================

Name: weight_read_sequencer

Overview:
Sequences reads from one neuron's weight memory (synchronous BRAM, 1-cycle registered read) in lock-step with that neuron's input-feature stream. For each accepted input, issues one weight read and emits a registered {input, weight} pair for the downstream MAC. Counts to the neuron's fan-in, flags the last pair, pulses done, and returns to idle. Sits between the layer input bus and Weight_Memory / the neuron MAC.

Parameters:
addressWidth, 10, weight memory address width; raddr is addressWidth+1 bits to match the memory port
dataWidth, 16, width of input features and weights
numWeight, 784, weights per neuron (fan-in); legal range 1..2**addressWidth

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
start  in  1  one-cycle pulse to begin a neuron pass
abort  in  1  synchronous flush back to IDLE
in_valid  in  1  input feature valid
in_data  in  dataWidth  input feature
in_ready  out  1  sequencer accepts in_data this cycle
ren  out  1  weight memory read enable
raddr  out  addressWidth+1  weight memory read address
wout  in  dataWidth  weight memory read data (valid the cycle after ren)
pair_valid  out  1  pair_x/pair_w valid
pair_x  out  dataWidth  aligned input feature
pair_w  out  dataWidth  aligned weight
pair_last  out  1  high with pair_valid on pair index numWeight-1
busy  out  1  high in RUN or DRAIN
done  out  1  one-cycle pulse after last pair is emitted

Behaviour:
- Reset (rst_n=0, async): state=IDLE, addr=0, all stage regs cleared; in_ready, ren, raddr, pair_valid, pair_x, pair_w, pair_last, busy, done all 0.
- States: IDLE, RUN, DRAIN, DONE.
- IDLE: in_ready=0. start=1 -> RUN, addr<=0. in_valid ignored.
- RUN: in_ready=1. accept = in_valid & in_ready. ren=accept (combinational); raddr=addr (zero-extended). On accept: addr<=addr+1; stage1 <= {valid=1, x=in_data, last=(addr==numWeight-1)}. Accept with addr==numWeight-1 -> DRAIN.
- Stage 2 (registered): pair_valid<=stage1.valid; pair_x<=stage1.x; pair_w<=wout; pair_last<=stage1.last. Accept-to-pair_valid latency = 2 cycles; back-to-back accepts yield back-to-back pairs; in_valid gaps produce matching pair_valid gaps. No backpressure from the consumer.
- DRAIN: in_ready=0, ren=0. Leaves when pair_last is emitted (pair_valid & pair_last) -> DONE.
- DONE: done=1 for exactly one cycle -> IDLE.
- busy=1 in RUN and DRAIN, 0 in IDLE and DONE.
- start outside IDLE: ignored. start and abort in the same cycle: abort wins.
- abort (any state): next state IDLE, addr<=0, stage1 and stage2 valid/last cleared, no done pulse; in_ready=0 and ren=0 in the abort cycle.
- numWeight=1: first accept goes straight to DRAIN; pair_valid and pair_last rise together 2 cycles later; done on the following cycle.
- addr never exceeds numWeight-1 at issue; no wrap within a pass.
- rst_n deasserted mid-pass: immediate return to reset values; the partial pass is lost.

Test Plan:
- Reset: hold rst_n=0 with start=1 and in_valid=1 -> all outputs 0; release, no activity until start.
- Full pass, numWeight=4, mem[i]=16'h0100+i, in_valid held high, in_data=10,11,12,13 -> ren on 4 consecutive cycles with raddr 0,1,2,3; pairs (10,0x100)...(13,0x103) starting 2 cycles after first accept; pair_last on 4th; done 1 cycle later; busy low after.
- Gapped input, numWeight=4, in_valid pattern 1,0,1,1,0,1 -> raddr only advances on accepts; pair_valid pattern is the same, delayed 2 cycles; pair_w matches mem[index].
- Abort after 2 accepts -> pair_valid drops the cycle after abort, no done pulse; a new start restarts at raddr=0.
- numWeight=1 and start pulsed during RUN -> single pair with pair_last=1, done pulse; the mid-run start has no effect.
- Async reset during DRAIN -> outputs cleared at once, no done; the next pass behaves like the full-pass case.

Source files
------------

// File: rtl/weight_read_sequencer.sv
// Weight-read sequencer: pairs each accepted input feature with the weight fetched
// from the neuron's 1-cycle-latency weight BRAM, and flags/finishes the fan-in pass.
module weight_read_sequencer #(
    parameter int addressWidth = 10,
    parameter int dataWidth    = 16,
    parameter int numWeight    = 784
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start,
    input  logic                    abort,
    input  logic                    in_valid,
    input  logic [dataWidth-1:0]    in_data,
    output logic                    in_ready,
    output logic                    ren,
    output logic [addressWidth:0]   raddr,
    input  logic [dataWidth-1:0]    wout,
    output logic                    pair_valid,
    output logic [dataWidth-1:0]    pair_x,
    output logic [dataWidth-1:0]    pair_w,
    output logic                    pair_last,
    output logic                    busy,
    output logic                    done
);

    localparam int AW1 = addressWidth + 1;
    localparam logic [AW1-1:0] LAST_ADDR = AW1'(numWeight - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t                 state_q, state_d;
    logic [AW1-1:0]         addr_q, addr_d;

    logic                   s1_vld_q, s1_vld_d;
    logic [dataWidth-1:0]   s1_x_q, s1_x_d;
    logic                   s1_last_q, s1_last_d;

    logic                   pair_valid_q, pair_valid_d;
    logic [dataWidth-1:0]   pair_x_q, pair_x_d;
    logic [dataWidth-1:0]   pair_w_q, pair_w_d;
    logic                   pair_last_q, pair_last_d;

    logic                   ready_c;
    logic                   accept_c;

    always_comb begin
        state_d      = state_q;
        addr_d       = addr_q;
        ready_c      = 1'b0;
        accept_c     = 1'b0;
        // Stage 1 only holds a valid beat in the cycle right after an accept.
        s1_vld_d     = 1'b0;
        s1_x_d       = s1_x_q;
        s1_last_d    = 1'b0;
        // Stage 2 lines the feature up with the BRAM data that arrives one cycle after ren.
        pair_valid_d = s1_vld_q;
        pair_x_d     = s1_x_q;
        pair_w_d     = wout;
        pair_last_d  = s1_last_q;

        if (abort) begin
            state_d      = S_IDLE;
            addr_d       = '0;
            pair_valid_d = 1'b0;
            pair_last_d  = 1'b0;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    if (start) begin
                        state_d = S_RUN;
                        addr_d  = '0;
                    end
                end
                S_RUN: begin
                    ready_c  = 1'b1;
                    accept_c = in_valid;
                    if (in_valid) begin
                        addr_d    = addr_q + AW1'(1);
                        s1_vld_d  = 1'b1;
                        s1_x_d    = in_data;
                        s1_last_d = (addr_q == LAST_ADDR);
                        if (addr_q == LAST_ADDR) begin
                            state_d = S_DRAIN;
                        end
                    end
                end
                S_DRAIN: begin
                    if (pair_valid_q && pair_last_q) begin
                        state_d = S_DONE;
                    end
                end
                S_DONE: begin
                    state_d = S_IDLE;
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            addr_q       <= '0;
            s1_vld_q     <= 1'b0;
            s1_x_q       <= '0;
            s1_last_q    <= 1'b0;
            pair_valid_q <= 1'b0;
            pair_x_q     <= '0;
            pair_w_q     <= '0;
            pair_last_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            addr_q       <= addr_d;
            s1_vld_q     <= s1_vld_d;
            s1_x_q       <= s1_x_d;
            s1_last_q    <= s1_last_d;
            pair_valid_q <= pair_valid_d;
            pair_x_q     <= pair_x_d;
            pair_w_q     <= pair_w_d;
            pair_last_q  <= pair_last_d;
        end
    end

    assign in_ready   = ready_c;
    assign ren        = accept_c;
    assign raddr      = addr_q;
    assign pair_valid = pair_valid_q;
    assign pair_x     = pair_x_q;
    assign pair_w     = pair_w_q;
    assign pair_last  = pair_last_q;
    assign busy       = (state_q == S_RUN) || (state_q == S_DRAIN);
    assign done       = (state_q == S_DONE);

endmodule

// File: tb/tb_weight_read_sequencer.sv
// Bench for weight_read_sequencer: two instances (fan-in 4 and fan-in 1) share one
// stimulus stream and are each compared against a timed pass/scoreboard model.
module tb_weight_read_sequencer;

    localparam int AW = 3;
    localparam int DW = 16;

    logic clk = 1'b0;
    logic rst_n;
    logic start, abort, in_valid;
    logic [DW-1:0] in_data;

    logic          in_ready_o   [2];
    logic          ren_o        [2];
    logic [AW:0]   raddr_o      [2];
    logic [DW-1:0] wout_i       [2];
    logic          pair_valid_o [2];
    logic [DW-1:0] pair_x_o     [2];
    logic [DW-1:0] pair_w_o     [2];
    logic          pair_last_o  [2];
    logic          busy_o       [2];
    logic          done_o       [2];

    logic [DW-1:0] mem [0:15];

    int checks = 0;
    int failures = 0;
    int t = 0;

    string nm [2] = '{"u4", "u1"};
    int    NW [2] = '{4, 1};

    // Reference model: pass bookkeeping plus a timed slot table of expected pairs.
    bit            m_run [2];
    bit            m_dp  [2];
    int            m_cnt [2];
    int            m_due [2];
    bit            sv [2][4];
    bit            sl [2][4];
    logic [DW-1:0] sx [2][4];
    logic [DW-1:0] sw [2][4];

    always #5 clk = ~clk;

    weight_read_sequencer #(.addressWidth(AW), .dataWidth(DW), .numWeight(4)) u4 (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
        .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready_o[0]),
        .ren(ren_o[0]), .raddr(raddr_o[0]), .wout(wout_i[0]),
        .pair_valid(pair_valid_o[0]), .pair_x(pair_x_o[0]), .pair_w(pair_w_o[0]),
        .pair_last(pair_last_o[0]), .busy(busy_o[0]), .done(done_o[0])
    );

    weight_read_sequencer #(.addressWidth(AW), .dataWidth(DW), .numWeight(1)) u1 (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
        .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready_o[1]),
        .ren(ren_o[1]), .raddr(raddr_o[1]), .wout(wout_i[1]),
        .pair_valid(pair_valid_o[1]), .pair_x(pair_x_o[1]), .pair_w(pair_w_o[1]),
        .pair_last(pair_last_o[1]), .busy(busy_o[1]), .done(done_o[1])
    );

    // Synchronous BRAMs with one-cycle registered read.
    always @(posedge clk) begin
        if (ren_o[0]) wout_i[0] <= mem[raddr_o[0]];
        if (ren_o[1]) wout_i[1] <= mem[raddr_o[1]];
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s t=%0d observed=%0h expected=%0h", tag, t, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_run[i] = 0; m_dp[i] = 0; m_cnt[i] = 0; m_due[i] = -1;
            for (int s = 0; s < 4; s++) begin
                sv[i][s] = 0; sl[i][s] = 0; sx[i][s] = '0; sw[i][s] = '0;
            end
        end
    endtask

    task automatic chk_zero();
        for (int i = 0; i < 2; i++) begin
            chk({nm[i], " rst in_ready"},   32'(in_ready_o[i]),   0);
            chk({nm[i], " rst ren"},        32'(ren_o[i]),        0);
            chk({nm[i], " rst raddr"},      32'(raddr_o[i]),      0);
            chk({nm[i], " rst pair_valid"}, 32'(pair_valid_o[i]), 0);
            chk({nm[i], " rst pair_x"},     32'(pair_x_o[i]),     0);
            chk({nm[i], " rst pair_w"},     32'(pair_w_o[i]),     0);
            chk({nm[i], " rst pair_last"},  32'(pair_last_o[i]),  0);
            chk({nm[i], " rst busy"},       32'(busy_o[i]),       0);
            chk({nm[i], " rst done"},       32'(done_o[i]),       0);
        end
    endtask

    // One clock cycle: drive at the falling edge, check, advance the model, wait a cycle.
    task automatic cycd(input bit st, input bit ab, input bit iv, input logic [DW-1:0] x);
        bit exp_rdy, exp_ren, idle, last;
        int s, s2;
        start = st; abort = ab; in_valid = iv; in_data = x;
        #1;
        s  = t % 4;
        s2 = (t + 2) % 4;
        for (int i = 0; i < 2; i++) begin
            exp_rdy = m_run[i] && !ab;
            exp_ren = exp_rdy && iv;
            chk({nm[i], " in_ready"},   32'(in_ready_o[i]),   32'(exp_rdy));
            chk({nm[i], " ren"},        32'(ren_o[i]),        32'(exp_ren));
            if (exp_ren) chk({nm[i], " raddr"}, 32'(raddr_o[i]), 32'(m_cnt[i]));
            chk({nm[i], " pair_valid"}, 32'(pair_valid_o[i]), 32'(sv[i][s]));
            chk({nm[i], " pair_last"},  32'(pair_last_o[i]),  32'(sv[i][s] && sl[i][s]));
            if (sv[i][s]) begin
                chk({nm[i], " pair_x"}, 32'(pair_x_o[i]), 32'(sx[i][s]));
                chk({nm[i], " pair_w"}, 32'(pair_w_o[i]), 32'(sw[i][s]));
            end
            chk({nm[i], " busy"}, 32'(busy_o[i]), 32'(m_run[i] || (m_dp[i] && t < m_due[i])));
            chk({nm[i], " done"}, 32'(done_o[i]), 32'(m_dp[i] && t == m_due[i]));

            idle = !m_run[i] && !m_dp[i];
            sv[i][s] = 0;
            if (ab) begin
                m_run[i] = 0; m_dp[i] = 0; m_cnt[i] = 0;
                for (int k = 0; k < 4; k++) sv[i][k] = 0;
            end else begin
                if (m_dp[i] && t == m_due[i]) m_dp[i] = 0;
                if (m_run[i] && iv) begin
                    last = (m_cnt[i] == NW[i] - 1);
                    sv[i][s2] = 1;
                    sx[i][s2] = x;
                    sw[i][s2] = mem[m_cnt[i]];
                    sl[i][s2] = last;
                    m_cnt[i]++;
                    if (last) begin
                        m_run[i] = 0; m_dp[i] = 1; m_due[i] = t + 3;
                    end
                end else if (idle && st) begin
                    m_run[i] = 1; m_cnt[i] = 0;
                end
            end
        end
        t++;
        @(negedge clk);
    endtask

    task automatic cyc(input bit st, input bit ab, input bit iv);
        cycd(st, ab, iv, DW'($urandom));
    endtask

    task automatic async_reset();
        start = 0; abort = 0; in_valid = 0;
        rst_n = 1'b0;
        #1;
        chk_zero();
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        for (int i = 0; i < 16; i++) mem[i] = DW'($urandom);
        for (int i = 0; i < 4; i++) mem[i] = DW'(16'h0100 + i);
        model_reset();

        // Reset held with start and in_valid asserted.
        rst_n = 1'b0; start = 1'b1; abort = 1'b0; in_valid = 1'b1; in_data = 16'h55;
        repeat (3) @(negedge clk);
        #1;
        chk_zero();
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) cyc(0, 0, 1);

        // Full pass, back-to-back inputs 10..13.
        cyc(1, 0, 0);
        for (int k = 0; k < 4; k++) cycd(0, 0, 1, DW'(10 + k));
        repeat (5) cyc(0, 0, 0);

        // Gapped input stream.
        cyc(1, 0, 0);
        cyc(0, 0, 1); cyc(0, 0, 0); cyc(0, 0, 1);
        cyc(0, 0, 1); cyc(0, 0, 0); cyc(0, 0, 1);
        repeat (5) cyc(0, 0, 0);

        // Abort after two accepts, then restart from address 0.
        cyc(1, 0, 0);
        cyc(0, 0, 1); cyc(0, 0, 1);
        cyc(0, 1, 1);
        repeat (3) cyc(0, 0, 0);
        cyc(1, 0, 0);
        repeat (4) cyc(0, 0, 1);
        repeat (5) cyc(0, 0, 0);

        // start together with abort in idle: abort wins.
        cyc(1, 1, 0);
        cyc(0, 0, 1);

        // start pulsed mid-run is ignored.
        cyc(1, 0, 0);
        cyc(0, 0, 1); cyc(1, 0, 1); cyc(0, 0, 1); cyc(1, 0, 1);
        repeat (5) cyc(0, 0, 0);

        // Async reset while draining, then a clean full pass.
        cyc(1, 0, 0);
        repeat (4) cyc(0, 0, 1);
        async_reset();
        repeat (2) cyc(0, 0, 0);
        cyc(1, 0, 0);
        for (int k = 0; k < 4; k++) cycd(0, 0, 1, DW'(10 + k));
        repeat (5) cyc(0, 0, 0);

        // Random traffic.
        for (int n = 0; n < 400; n++) begin
            cyc($urandom_range(0, 5) == 0, $urandom_range(0, 40) == 0, $urandom_range(0, 1) == 1);
        end
        repeat (5) cyc(0, 0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
